// File: rtl/aes_pkg.sv
// Shared constants and types for the area-reduced AES core's S-box scheduler.
package aes_pkg;

  localparam int BYTE_W   = 8;
  localparam int ST_BYTES = 16;
  localparam int KW_BYTES = 4;
  localparam int CNT_W    = 4;
  localparam int WORK_W   = ST_BYTES * BYTE_W;
  localparam int KW_W     = KW_BYTES * BYTE_W;

  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_BYTES - 1);
  localparam logic [CNT_W-1:0] KW_LAST = CNT_W'(KW_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } sched_state_e;

  typedef enum logic {
    GRANT_ST = 1'b0,
    GRANT_KW = 1'b1
  } grant_e;

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box: forward (dec=0) or inverse (dec=1) byte substitution,
// computed as GF(2^8) inversion plus the affine map instead of a ROM.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] U,
  input  logic              dec,
  output logic [BYTE_W-1:0] S
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    if (dec) S = gf_inv(inv_affine(U));
    else     S = fwd_affine(gf_inv(U));
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares one aes_sbox between the round datapath (16-byte jobs) and the key
// expander (4-byte SubWord jobs), streaming one byte per clock.
module aes_sbox_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic              st_dec,
  input  logic [WORK_W-1:0] st_din,
  output logic              st_ack,
  output logic              st_done,
  output logic [WORK_W-1:0] st_dout,
  input  logic              kw_req,
  input  logic [KW_W-1:0]   kw_din,
  output logic              kw_ack,
  output logic              kw_done,
  output logic [KW_W-1:0]   kw_dout,
  output logic              busy
);

  sched_state_e      state, state_nxt;
  grant_e            last_grant;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt;
  logic              dec_q;
  logic              last_byte;
  logic [BYTE_W-1:0] sbox_in;
  logic [BYTE_W-1:0] sbox_out;
  logic              sbox_dec;

  assign sbox_in  = work[WORK_W-1 -: BYTE_W];
  assign sbox_dec = (state == ST_RUN) ? dec_q : 1'b0;
  assign shifted  = {work[WORK_W-BYTE_W-1:0], sbox_out};
  assign busy     = (state != IDLE) && !rst;

  assign last_byte = ((state == ST_RUN) && (cnt == ST_LAST)) ||
                     ((state == KW_RUN) && (cnt == KW_LAST));

  aes_sbox u_sbox (
    .U   (sbox_in),
    .dec (sbox_dec),
    .S   (sbox_out)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    st_ack    = 1'b0;
    kw_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          // On a tie, grant whichever port did not win the previous grant.
          if (st_req && kw_req) begin
            if (last_grant == GRANT_ST) kw_ack = 1'b1;
            else                        st_ack = 1'b1;
          end else begin
            st_ack = st_req;
            kw_ack = kw_req;
          end
        end
        if (st_ack)      state_nxt = ST_RUN;
        else if (kw_ack) state_nxt = KW_RUN;
      end
      ST_RUN, KW_RUN: begin
        if (last_byte) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the work register is reset along with the control state so an
      // aborted job leaves no stale bytes; it is a single register, not a RAM.
      state      <= IDLE;
      last_grant <= GRANT_ST;
      work       <= '0;
      cnt        <= '0;
      dec_q      <= 1'b0;
      st_done    <= 1'b0;
      kw_done    <= 1'b0;
      st_dout    <= '0;
      kw_dout    <= '0;
    end else begin
      state   <= state_nxt;
      st_done <= 1'b0;
      kw_done <= 1'b0;
      if (st_ack) begin
        work       <= st_din;
        dec_q      <= st_dec;
        cnt        <= '0;
        last_grant <= GRANT_ST;
      end else if (kw_ack) begin
        work       <= {kw_din, {(WORK_W-KW_W){1'b0}}};
        dec_q      <= 1'b0;
        cnt        <= '0;
        last_grant <= GRANT_KW;
      end else if (state != IDLE) begin
        work <= shifted;
        cnt  <= cnt + CNT_W'(1);
        if (state == ST_RUN && last_byte) begin
          st_dout <= shifted;
          st_done <= 1'b1;
        end
        // After four shifts the key word's results occupy the low 32 bits.
        if (state == KW_RUN && last_byte) begin
          kw_dout <= shifted[KW_W-1:0];
          kw_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed-vector bench for aes_sbox_sched using FIPS-197 S-box values.
module tb_aes_sbox_sched;

  logic         clk;
  logic         rst;
  logic         st_req;
  logic         st_dec;
  logic [127:0] st_din;
  logic         st_ack;
  logic         st_done;
  logic [127:0] st_dout;
  logic         kw_req;
  logic [31:0]  kw_din;
  logic         kw_ack;
  logic         kw_done;
  logic [31:0]  kw_dout;
  logic         busy;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_SUB = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  KW_IN  = 32'hcf4f3c09;
  localparam logic [31:0]  KW_OUT = 32'h8a84eb01;

  aes_sbox_sched dut (
    .clk     (clk),
    .rst     (rst),
    .st_req  (st_req),
    .st_dec  (st_dec),
    .st_din  (st_din),
    .st_ack  (st_ack),
    .st_done (st_done),
    .st_dout (st_dout),
    .kw_req  (kw_req),
    .kw_din  (kw_din),
    .kw_ack  (kw_ack),
    .kw_done (kw_done),
    .kw_dout (kw_dout),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one state job from an idle scheduler and records what happens over
  // the next 20 cycles; cycle k counts from the ack cycle A.
  task automatic st_job(input logic [127:0] din, input logic dec,
                        output logic acked, output int done_at, output int done_cnt,
                        output int busy_cnt, output logic [127:0] dout, output logic stable);
    logic [127:0] prev;
    @(negedge clk);
    prev   = st_dout;
    st_din = din;
    st_dec = dec;
    st_req = 1'b1;
    #1 acked = st_ack;
    done_at = -1; done_cnt = 0; busy_cnt = 0; dout = '0; stable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      st_req = 1'b0;
      if (busy) busy_cnt++;
      if (st_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          dout    = st_dout;
        end
      end else if (done_at < 0 && st_dout !== prev) stable = 1'b0;
    end
  endtask

  task automatic kw_job(input logic [31:0] din, output logic acked, output int done_at,
                        output int done_cnt, output int busy_cnt, output logic [31:0] dout);
    @(negedge clk);
    kw_din = din;
    kw_req = 1'b1;
    #1 acked = kw_ack;
    done_at = -1; done_cnt = 0; busy_cnt = 0; dout = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      kw_req = 1'b0;
      if (busy) busy_cnt++;
      if (kw_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          dout    = kw_dout;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; st_req = 1'b0; kw_req = 1'b0; st_dec = 1'b0; st_din = '0; kw_din = '0;
    repeat (3) @(negedge clk);
    st_req = 1'b1; kw_req = 1'b1;
    #1;
    total++;
    if ({st_ack, kw_ack, st_done, kw_done, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {st_ack, kw_ack, st_done, kw_done, busy});
    else passed++;
    total++;
    if (st_dout !== 128'h0 || kw_dout !== 32'h0)
      $display("FAIL reset_data: got st=%h kw=%h want zero", st_dout, kw_dout);
    else passed++;
    @(negedge clk);
    st_req = 1'b0; kw_req = 1'b0; rst = 1'b0;
  endtask

  // Tie after reset goes to key; a tie on the kw_done cycle goes to state;
  // a tie on the st_done cycle goes back to key.
  task automatic test_tie();
    logic early_st_ack;
    logic [127:0] got_st;
    logic [31:0]  got_kw;
    logic saw_st_done, saw_kw_done;
    @(negedge clk);
    st_din = PT; st_dec = 1'b0; kw_din = KW_IN;
    st_req = 1'b1; kw_req = 1'b1;
    #1;
    total++;
    if (kw_ack !== 1'b1 || st_ack !== 1'b0)
      $display("FAIL tie_first: got kw_ack=%b st_ack=%b want 1 0", kw_ack, st_ack);
    else passed++;
    early_st_ack = 1'b0; saw_st_done = 1'b0; saw_kw_done = 1'b0; got_st = '0; got_kw = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) kw_req = 1'b0;
      if (k == 5) kw_req = 1'b1;
      #1;
      if (k < 5 && st_ack) early_st_ack = 1'b1;
      if (k == 5) begin
        total++;
        if (kw_done !== 1'b1 || st_ack !== 1'b1 || kw_ack !== 1'b0)
          $display("FAIL tie_on_kw_done: got kw_done=%b st_ack=%b kw_ack=%b want 1 1 0",
                   kw_done, st_ack, kw_ack);
        else passed++;
        total++;
        if (kw_dout !== KW_OUT) $display("FAIL tie_kw_dout: got %h want %h", kw_dout, KW_OUT);
        else passed++;
      end
      if (k == 6) st_req = 1'b0;
      if (k == 22) begin
        saw_st_done = st_done;
        got_st      = st_dout;
        total++;
        if (kw_ack !== 1'b1 || st_ack !== 1'b0)
          $display("FAIL tie_second: got kw_ack=%b st_ack=%b want 1 0", kw_ack, st_ack);
        else passed++;
        st_req = 1'b1;
      end
      if (k == 23) begin
        kw_req = 1'b0;
        st_req = 1'b0;
      end
      if (k == 27) begin
        saw_kw_done = kw_done;
        got_kw      = kw_dout;
      end
    end
    total++;
    if (early_st_ack !== 1'b0) $display("FAIL tie_no_early_ack: got 1 want 0");
    else passed++;
    total++;
    if (saw_st_done !== 1'b1 || got_st !== PT_SUB)
      $display("FAIL tie_st_result: got done=%b dout=%h want 1 %h", saw_st_done, got_st, PT_SUB);
    else passed++;
    total++;
    if (saw_kw_done !== 1'b1 || got_kw !== KW_OUT)
      $display("FAIL tie_kw_result: got done=%b dout=%h want 1 %h", saw_kw_done, got_kw, KW_OUT);
    else passed++;
  endtask

  task automatic test_key_job();
    logic acked; int done_at, done_cnt, busy_cnt; logic [31:0] dout;
    kw_job(KW_IN, acked, done_at, done_cnt, busy_cnt, dout);
    total++;
    if (acked !== 1'b1) $display("FAIL kw_ack: got %b want 1", acked);
    else passed++;
    total++;
    if (done_at != 5 || done_cnt != 1)
      $display("FAIL kw_latency: got done_at=%0d count=%0d want 5 1", done_at, done_cnt);
    else passed++;
    total++;
    if (busy_cnt != 4) $display("FAIL kw_busy: got %0d cycles want 4", busy_cnt);
    else passed++;
    total++;
    if (dout !== KW_OUT) $display("FAIL kw_dout: got %h want %h", dout, KW_OUT);
    else passed++;
  endtask

  task automatic test_state_roundtrip();
    logic acked, stable; int done_at, done_cnt, busy_cnt; logic [127:0] dout;
    st_job(PT, 1'b0, acked, done_at, done_cnt, busy_cnt, dout, stable);
    total++;
    if (acked !== 1'b1) $display("FAIL st_ack: got %b want 1", acked);
    else passed++;
    total++;
    if (done_at != 17 || done_cnt != 1)
      $display("FAIL st_latency: got done_at=%0d count=%0d want 17 1", done_at, done_cnt);
    else passed++;
    total++;
    if (busy_cnt != 16) $display("FAIL st_busy: got %0d cycles want 16", busy_cnt);
    else passed++;
    total++;
    if (dout !== PT_SUB) $display("FAIL st_enc: got %h want %h", dout, PT_SUB);
    else passed++;
    st_job(PT_SUB, 1'b1, acked, done_at, done_cnt, busy_cnt, dout, stable);
    total++;
    if (done_at != 17 || dout !== PT)
      $display("FAIL st_dec: got done_at=%0d dout=%h want 17 %h", done_at, dout, PT);
    else passed++;
  endtask

  task automatic test_req_during_run();
    logic early_kw_ack;
    logic [31:0] got_kw;
    logic saw_kw_done;
    @(negedge clk);
    st_din = PT; st_dec = 1'b0; st_req = 1'b1;
    #1;
    total++;
    if (st_ack !== 1'b1) $display("FAIL run_st_ack: got %b want 1", st_ack);
    else passed++;
    early_kw_ack = 1'b0; saw_kw_done = 1'b0; got_kw = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) st_req = 1'b0;
      if (k == 3) begin
        kw_din = KW_IN;
        kw_req = 1'b1;
      end
      #1;
      if (k < 17 && kw_ack) early_kw_ack = 1'b1;
      if (k == 17) begin
        total++;
        if (kw_ack !== 1'b1 || st_done !== 1'b1)
          $display("FAIL run_ack_on_done: got kw_ack=%b st_done=%b want 1 1", kw_ack, st_done);
        else passed++;
      end
      if (k == 18) kw_req = 1'b0;
      if (k == 22) begin
        saw_kw_done = kw_done;
        got_kw      = kw_dout;
      end
    end
    total++;
    if (early_kw_ack !== 1'b0) $display("FAIL run_no_early_ack: got 1 want 0");
    else passed++;
    total++;
    if (saw_kw_done !== 1'b1 || got_kw !== KW_OUT)
      $display("FAIL run_kw_result: got done=%b dout=%h want 1 %h", saw_kw_done, got_kw, KW_OUT);
    else passed++;
  endtask

  task automatic test_reset_mid_job();
    logic saw_done;
    logic acked, stable; int done_at, done_cnt, busy_cnt; logic [127:0] dout;
    @(negedge clk);
    st_din = PT; st_dec = 1'b0; st_req = 1'b1;
    saw_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      st_req = 1'b0;
      if (k == 8) rst = 1'b1;
      if (k == 9) begin
        rst = 1'b0;
        total++;
        if (st_done !== 1'b0 || st_dout !== 128'h0 || busy !== 1'b0)
          $display("FAIL abort_state: got done=%b dout=%h busy=%b want 0 0 0",
                   st_done, st_dout, busy);
        else passed++;
      end
      if (st_done) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: got 1 want 0");
    else passed++;
    st_job(PT, 1'b0, acked, done_at, done_cnt, busy_cnt, dout, stable);
    total++;
    if (acked !== 1'b1 || done_at != 17 || dout !== PT_SUB)
      $display("FAIL abort_fresh_job: got ack=%b done_at=%0d dout=%h want 1 17 %h",
               acked, done_at, dout, PT_SUB);
    else passed++;
  endtask

  task automatic test_zero_patterns();
    logic acked, stable; int done_at, done_cnt, busy_cnt; logic [127:0] dout;
    st_job(128'h0, 1'b0, acked, done_at, done_cnt, busy_cnt, dout, stable);
    total++;
    if (dout !== {16{8'h63}}) $display("FAIL zero_enc: got %h want %h", dout, {16{8'h63}});
    else passed++;
    total++;
    if (stable !== 1'b1) $display("FAIL dout_stable_enc: st_dout changed before done");
    else passed++;
    st_job({16{8'h63}}, 1'b1, acked, done_at, done_cnt, busy_cnt, dout, stable);
    total++;
    if (dout !== 128'h0) $display("FAIL all63_dec: got %h want 0", dout);
    else passed++;
    total++;
    if (stable !== 1'b1) $display("FAIL dout_stable_dec: st_dout changed before done");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_key_job();
    test_state_roundtrip();
    test_req_during_run();
    test_reset_mid_job();
    test_zero_patterns();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
